// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: runs one WIDTH-bit add/sub/and/or through a 1-bit
// slice, LSB first, with valid/ready handshakes on both sides.
module serial_alu_seq #(
    parameter int  WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             bt_x;
    logic             sum;
    logic             cout;
    logic             rbit;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // One slice evaluation on the current LSBs of the operand shifters.
    always_comb begin
        bt_x     = op[0] ? ~b_sh[0] : b_sh[0];
        sum      = a_sh[0] ^ bt_x ^ carry;
        cout     = (a_sh[0] & bt_x) | (a_sh[0] & carry) | (bt_x & carry);
        rbit     = sum;
        case (op)
            2'b10:   rbit = a_sh[0] & b_sh[0];
            2'b11:   rbit = a_sh[0] | b_sh[0];
            default: rbit = sum;
        endcase
        res_next = {rbit, res_sh[WIDTH-1:1]};
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op       <= ALUcontrol;
                        carry    <= ALUcontrol[0];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= cout;
                    if (last) begin
                        // carry still holds the MSB carry-in here, cout is the carry-out.
                        result    <= res_next;
                        Z         <= ~|res_next;
                        N         <= rbit;
                        C         <= ~op[1] & cout;
                        V         <= ~op[1] & (carry ^ cout);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   ALUcontrol;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         Z, N, C, V;

    int checks = 0;
    int errors = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUcontrol(ALUcontrol),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic [3:0]   znvc;
    } vec_t;

    function automatic vec_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [1:0] op);
        vec_t        r;
        logic [W:0]  wide;
        logic        cf, vf;
        r.a = x; r.b = y; r.op = op;
        cf = 1'b0; vf = 1'b0;
        case (op)
            2'b00: begin
                wide  = {1'b0, x} + {1'b0, y};
                r.res = wide[W-1:0];
                cf    = wide[W];
                vf    = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            2'b01: begin
                wide  = {1'b0, x} + {1'b0, ~y} + 1;
                r.res = wide[W-1:0];
                cf    = (x >= y);
                vf    = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            2'b10: r.res = x & y;
            default: r.res = x | y;
        endcase
        r.znvc = {(r.res == 0), r.res[W-1], vf, cf};
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for in_ready, then presents the operation for exactly one accept edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid   = 1'b1;
        a          = x;
        b          = y;
        ALUcontrol = op;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        a          = $urandom;
        b          = $urandom;
        ALUcontrol = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", W'(out_valid), 0);
        check("in_ready_after_hs", W'(in_ready), 1);
    endtask

    task automatic run_check(input string tag, input vec_t v);
        int lat;
        issue(v.a, v.b, v.op);
        wait_done(lat);
        check({tag, "_latency"}, W'(lat), W);
        check({tag, "_result"}, result, v.res);
        check({tag, "_znvc"}, W'({Z, N, V, C}), W'(v.znvc));
        handshake();
    endtask

    vec_t tbl[5];
    vec_t v;
    logic [W-1:0] held;
    int lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ALUcontrol = 2'b00;

        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b0110};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'b1001};
        tbl[2] = '{32'h0000_0003, 32'h0000_0005, 2'b01, 32'hFFFF_FFFE, 4'b0100};
        tbl[3] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00F0_00F0, 4'b0000};
        tbl[4] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 32'hFFF0_FFF0, 4'b0100};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_flags", W'({Z, N, C, V}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_check($sformatf("vec%0d", i), tbl[i]);

        // Backpressure with a new request pending during DONE.
        v = ref_model(32'h1234_5678, 32'h1111_1111, 2'b00);
        issue(v.a, v.b, v.op);
        wait_done(lat);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            a          = 32'hDEAD_BEEF;
            b          = 32'h0000_0011;
            ALUcontrol = 2'b01;
            @(posedge clk);
            #1;
            check("bp_out_valid", W'(out_valid), 1);
            check("bp_in_ready", W'(in_ready), 0);
            check("bp_result", result, held);
        end
        in_valid = 1'b0;
        check("bp_result_val", held, v.res);
        handshake();
        run_check("bp_next", ref_model(32'hDEAD_BEEF, 32'h0000_0011, 2'b01));

        // Reset in the middle of RUN, then a clean operation afterwards.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", W'(in_ready), 1);
        check("midrst_out_valid", W'(out_valid), 0);
        check("midrst_result", result, 0);
        check("midrst_flags", W'({Z, N, C, V}), 0);
        @(negedge clk);
        rst = 1'b0;
        run_check("post_rst", '{32'h2, 32'h3, 2'b00, 32'h5, 4'b0000});

        // Randomized operations with occasional boundary operands.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i % 5 == 0) x = 32'h8000_0000;
            if (i % 7 == 0) y = 32'hFFFF_FFFF;
            if (i % 11 == 0) y = x;
            run_check($sformatf("rnd%0d", i), ref_model(x, y, 2'($urandom_range(0, 3))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial sequencer that computes one full WIDTH-bit ALU operation by iterating a 1-bit ALU slice over the operands, LSB first.
- Owns the slice internally: a carry flop, operand shift registers, a result shift register and a bit counter.
- Sits between the FPU control path and the integer/mantissa datapath, and gives an area-cheap alternative to a parallel WIDTH-bit ALU.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ALUcontrol  in  2  00 add, 01 sub (A + ~B + 1), 10 AND, 11 OR.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- Z  out  1  result == 0.
- N  out  1  result[WIDTH-1].
- C  out  1  arithmetic carry-out (sub: 1 = no borrow); 0 for AND/OR.
- V  out  1  signed overflow for add/sub; 0 for AND/OR.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; in_ready=1; out_valid=0; result=0; Z=0 N=0 C=0 V=0; counter=0; carry flop=0. Reset takes priority over every other event, including mid-RUN and mid-DONE, where the operation in progress is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a, b and ALUcontrol into internal registers; carry flop ← ALUcontrol[0]; counter ← 0; go to RUN.
- RUN:
  - in_ready=0. One bit per cycle at index = counter.
  - Bit slice: bt' = ALUcontrol[0] ? ~bt : bt. sum = at ^ bt' ^ carry. cout = majority(at, bt', carry).
  - Result bit select: 00/01 → sum, 10 → at&bt, 11 → at|bt.
  - Per edge: the result shift register shifts right and the new bit enters the MSB; operand registers shift right; carry ← cout (updated for every op code, but only used for arithmetic).
  - At counter = WIDTH-1: record carry_in_msb = carry (before update) and carry_out = cout; go to DONE.
  - Otherwise counter ← counter+1.
- DONE:
  - out_valid=1; result/Z/N/C/V stable until the handshake.
  - C = ~ALUcontrol[1] & carry_out.
  - V = ~ALUcontrol[1] & (carry_in_msb ^ carry_out).
  - Z = ~|result. N = result[WIDTH-1].
  - On out_ready=1: go to IDLE, out_valid=0 next cycle.
  - Result and flags keep their last values in IDLE (not cleared).
- Latency: accept edge E → out_valid high after edge E+WIDTH (32 cycles for the default). Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN edges, handshake edge).
- in_ready is 0 in RUN and DONE. in_valid during RUN/DONE is ignored (no queueing); the requester must hold it until in_ready.
- out_ready while not in DONE is ignored. out_ready held high makes DONE last exactly one cycle.
- Changes to a/b/ALUcontrol after acceptance have no effect on the operation in progress.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; all outputs are registered or decoded from state.

Test Plan:
- Add overflow: a=0x7FFFFFFF, b=0x00000001, ALUcontrol=00 → result=0x80000000, N=1, V=1, C=0, Z=0. out_valid asserts exactly 32 edges after acceptance.
- Sub equal: a=0x00000005, b=0x00000005, ALUcontrol=01 → result=0x00000000, Z=1, C=1, V=0, N=0.
- Sub borrow: a=0x00000003, b=0x00000005, ALUcontrol=01 → result=0xFFFFFFFE, N=1, C=0, V=0.
- Logic ops: a=0xF0F0F0F0, b=0x0FF00FF0. ALUcontrol=10 → result=0x00F000F0, C=0, V=0. ALUcontrol=11 → result=0xFFF0FFF0, N=1.
- Backpressure and ignored input: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands. Required: out_valid stays 1, result unchanged, in_ready=0. Raising out_ready completes the handshake, then the new operation is accepted in IDLE.
- Reset mid-RUN: assert rst at counter=12 of a 0xFFFFFFFF+0x1 add. Next cycle: IDLE, in_ready=1, out_valid=0, result=0, all flags 0. A following 0x2+0x3 add yields 0x00000005 with no residue from the carry flop.
